// File: rtl/axi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi_mem_pkg
// Description : Shared encodings, FSM states and lane-mask helper for the
//               AXI4 burst memory model.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    // Lanes from the beat address up to the next size boundary within a bus of nb bytes
    function automatic logic [7:0] lane_mask(input logic [2:0] addr_lo,
                                             input logic [2:0] size,
                                             input int         nb);
        int sz;
        int lo;
        int hi;
        sz = 1 << size;
        lo = int'(addr_lo) & (nb - 1);
        hi = ((int'(addr_lo) & ~(sz - 1)) & (nb - 1)) + sz;
        for (int i = 0; i < 8; i++) begin
            lane_mask[i] = (i < nb) && (i >= lo) && (i < hi);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_sum;
    logic [ADDR_W-1:0] w_wrap_bytes;
    logic              w_wrap_ok;

    assign w_incr       = ADDR_W'(1) << i_size;
    assign w_sum        = i_addr + w_incr;
    assign w_wrap_bytes = ADDR_W'({1'b0, i_len} + 9'd1) << i_size;
    assign w_wrap_ok    = (i_len == 8'd1) || (i_len == 8'd3) ||
                          (i_len == 8'd7) || (i_len == 8'd15);

    // Illegal wrap lengths fall back to incrementing
    always_comb begin
        o_next_addr = w_sum;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_WRAP: begin
                if (w_wrap_ok) begin
                    o_next_addr = (i_addr & ~(w_wrap_bytes - ADDR_W'(1))) |
                                  (w_sum  &  (w_wrap_bytes - ADDR_W'(1)));
                end
            end
            default: o_next_addr = w_sum;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_burst_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_mem_model
// Description : AXI4 burst slave memory with read latency and console sink.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_mem_model
    import axi_mem_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter int              DATA_W       = 32,
    parameter int              ID_W         = 1,
    parameter int              MEM_BYTES    = 65536,
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int              READ_LAT     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [ID_W-1:0]     awid,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [ID_W-1:0]     arid,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [ID_W-1:0]     rid,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                console_valid,
    output logic [7:0]          console_data,
    output logic                protocol_err
);

    localparam int         c_nb       = DATA_W / 8;
    localparam int         c_nb_log2  = $clog2(c_nb);
    localparam int         c_mem_aw   = $clog2(MEM_BYTES);
    localparam int         c_lat_w    = $clog2(READ_LAT + 1);
    localparam logic [2:0] c_max_size = 3'(c_nb_log2);

    logic [7:0] r_mem [MEM_BYTES];

    // ------------------------------------------------------------ write side
    wr_state_t         r_wstate, w_wstate_nxt;
    logic [ADDR_W-1:0] r_waddr, w_wnext;
    logic [ID_W-1:0]   r_wid;
    logic [7:0]        r_wlen, r_wbeat;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst, r_bresp;
    logic              r_perr;
    logic              w_w_hs, w_wsize_err, w_w_inmem, w_w_console, w_w_commit;
    logic [c_nb-1:0]   w_wmask;
    logic [c_mem_aw-1:0] w_wbase;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
        .i_addr(r_waddr), .i_size(r_wsize), .i_len(r_wlen),
        .i_burst(r_wburst), .o_next_addr(w_wnext)
    );

    assign w_w_hs      = (r_wstate == W_DATA) && wvalid;
    assign w_wsize_err = r_wsize > c_max_size;
    assign w_w_inmem   = (r_waddr >> c_mem_aw) == '0;
    assign w_w_console = r_waddr == CONSOLE_ADDR;
    assign w_w_commit  = w_w_hs && !w_wsize_err && w_w_inmem;
    assign w_wmask     = c_nb'(lane_mask(r_waddr[2:0], r_wsize, c_nb));
    assign w_wbase     = {r_waddr[c_mem_aw-1:c_nb_log2], {c_nb_log2{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (awvalid) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && (r_wbeat == r_wlen)) w_wstate_nxt = W_RESP;
            W_RESP:  if (bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        awready       = (r_wstate == W_IDLE) && !rst;
        wready        = (r_wstate == W_DATA);
        bvalid        = (r_wstate == W_RESP);
        bid           = r_wid;
        bresp         = r_bresp;
        console_valid = w_w_hs && w_w_console && wstrb[0] && !w_wsize_err;
        console_data  = wdata[7:0];
        protocol_err  = r_perr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr  <= '0;
            r_wid    <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wbeat  <= '0;
            r_bresp  <= RESP_OKAY;
            r_perr   <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                r_waddr  <= awaddr;
                r_wid    <= awid;
                r_wlen   <= awlen;
                r_wsize  <= awsize;
                r_wburst <= awburst;
                r_wbeat  <= '0;
                r_bresp  <= (awsize > c_max_size) ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_w_hs) begin
                r_wbeat <= r_wbeat + 8'd1;
                r_waddr <= w_wnext;
                if (!w_wsize_err && !w_w_inmem && !w_w_console) r_bresp <= RESP_DECERR;
                if (wlast != (r_wbeat == r_wlen)) r_perr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_nb; i++) begin
            if (w_w_commit && wstrb[i] && w_wmask[i]) begin
                r_mem[w_wbase + c_mem_aw'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------- read side
    rd_state_t           r_rstate, w_rstate_nxt;
    logic [ADDR_W-1:0]   r_raddr, w_rnext, w_rload_addr;
    logic [ID_W-1:0]     r_rid;
    logic [7:0]          r_rlen, r_rbeat;
    logic [2:0]          r_rsize;
    logic [1:0]          r_rburst, r_rresp, w_rd_resp;
    logic [c_lat_w-1:0]  r_lat_cnt;
    logic [DATA_W-1:0]   r_rdata, w_rword, w_rd_data;
    logic                r_rlast;
    logic                w_r_hs, w_r_load_first, w_r_load_next;
    logic [c_mem_aw-1:0] w_rbase;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
        .i_addr(r_raddr), .i_size(r_rsize), .i_len(r_rlen),
        .i_burst(r_rburst), .o_next_addr(w_rnext)
    );

    // Beat data is captured into registers so it holds steady under back-pressure
    assign w_r_hs         = (r_rstate == R_DATA) && rready;
    assign w_r_load_first = (r_rstate == R_WAIT) && (r_lat_cnt == '0);
    assign w_r_load_next  = w_r_hs && (r_rbeat != r_rlen);
    assign w_rload_addr   = (r_rstate == R_DATA) ? w_rnext : r_raddr;
    assign w_rbase        = {w_rload_addr[c_mem_aw-1:c_nb_log2], {c_nb_log2{1'b0}}};

    always_comb begin
        w_rword = '0;
        for (int i = 0; i < c_nb; i++) begin
            w_rword[8*i +: 8] = r_mem[w_rbase + c_mem_aw'(i)];
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (r_rsize > c_max_size) begin
            w_rd_resp = RESP_SLVERR;
        end else if ((w_rload_addr >> c_mem_aw) == '0) begin
            w_rd_data = w_rword;
        end else if (w_rload_addr != CONSOLE_ADDR) begin
            w_rd_resp = RESP_DECERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (arvalid) w_rstate_nxt = R_WAIT;
            R_WAIT:  if (r_lat_cnt == '0) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && (r_rbeat == r_rlen)) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_rstate == R_IDLE) && !rst;
        rvalid  = (r_rstate == R_DATA);
        rdata   = r_rdata;
        rid     = r_rid;
        rresp   = r_rresp;
        rlast   = r_rlast;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr   <= '0;
            r_rid     <= '0;
            r_rlen    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
            r_rbeat   <= '0;
            r_lat_cnt <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= 1'b0;
        end else begin
            if (arvalid && arready) begin
                r_raddr   <= araddr;
                r_rid     <= arid;
                r_rlen    <= arlen;
                r_rsize   <= arsize;
                r_rburst  <= arburst;
                r_rbeat   <= '0;
                r_lat_cnt <= c_lat_w'(READ_LAT - 1);
            end
            if ((r_rstate == R_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - c_lat_w'(1);
            end
            if (w_r_load_first) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
                r_rlast <= (r_rlen == 8'd0);
            end
            if (w_r_load_next) begin
                r_raddr <= w_rnext;
                r_rbeat <= r_rbeat + 8'd1;
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
                r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
            end
            if (w_r_hs && (r_rbeat == r_rlen)) r_rlast <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_mem_model
// Description : Directed self-checking bench for the AXI4 burst memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_mem_model;
    import axi_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [0:0]  awid, bid, arid, rid;
    logic [7:0]  awlen, arlen, console_data;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic        console_valid, protocol_err;

    always #5 clk = ~clk;

    axi_burst_mem_model dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
        .rresp(rresp), .rlast(rlast),
        .console_valid(console_valid), .console_data(console_data),
        .protocol_err(protocol_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf_data [16];
    logic [1:0]  rbuf_resp [16];
    logic        rbuf_last [16];
    logic [0:0]  rbuf_id   [16];
    int          rlat;

    int          con_cnt  = 0;
    logic [7:0]  con_data = 8'h00;

    always @(posedge clk) begin
        if (console_valid) begin
            con_cnt  <= con_cnt + 1;
            con_data <= console_data;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [0:0] id, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bu, input int bad,
                             output logic [1:0] resp, output logic [0:0] bid_o);
        int   t;
        int   to;
        logic early;
        to = 0;
        early = 1'b0;
        @(negedge clk);
        awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bu;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) to++;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b];
            wlast  = (b == int'(len)) != (b == bad);
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) to++;
            early = early | bvalid;
            @(posedge clk);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) to++;
        resp  = bresp;
        bid_o = bid;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        chk("wr_handshake_timeouts", 64'(to), 64'd0);
        if (bad >= 0) chk("bvalid_before_last_beat", {63'd0, early}, 64'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [0:0] id, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu,
                            input int stall_at, input int stall_n);
        int          t;
        int          to;
        logic        stable;
        logic [31:0] sd;
        logic        sl;
        logic [0:0]  si;
        to = 0;
        @(negedge clk);
        arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) to++;
        @(posedge clk);
        rlat = 0;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        t = 0;
        while (!rvalid && t < 50) begin @(posedge clk); rlat++; @(negedge clk); t++; end
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!rvalid && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) to++;
            if (b == stall_at) begin
                rready = 1'b0;
                sd = rdata; sl = rlast; si = rid;
                stable = 1'b1;
                repeat (stall_n) begin
                    @(negedge clk);
                    if (!(rvalid && rdata == sd && rlast == sl && rid == si)) stable = 1'b0;
                end
                chk("r_stall_stable", {63'd0, stable}, 64'd1);
                rready = 1'b1;
            end
            rbuf_data[b] = rdata; rbuf_resp[b] = rresp;
            rbuf_last[b] = rlast; rbuf_id[b]   = rid;
            @(posedge clk);
            @(negedge clk);
        end
        rready = 1'b0;
        chk("rd_handshake_timeouts", 64'(to), 64'd0);
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [2:0]  wsize;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [1:0]  exp_bresp;
        logic [31:0] raddr;
        logic [2:0]  rsize;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [1:0] resp;
        logic [0:0] bidv;

        vecs[0] = '{32'h200,   3'd0 + 3'd2, 4'hF, 32'h11223344, RESP_OKAY,   32'h200,   3'd2, 32'h11223344, RESP_OKAY};
        vecs[1] = '{32'h203,   3'd0,        4'h8, 32'hAB000000, RESP_OKAY,   32'h200,   3'd2, 32'hAB223344, RESP_OKAY};
        vecs[2] = '{32'h201,   3'd0,        4'h2, 32'h0000CD00, RESP_OKAY,   32'h200,   3'd2, 32'hAB22CD44, RESP_OKAY};
        vecs[3] = '{32'h202,   3'd1,        4'hC, 32'hBEEF0000, RESP_OKAY,   32'h200,   3'd2, 32'hBEEFCD44, RESP_OKAY};
        vecs[4] = '{32'h200,   3'd3,        4'hF, 32'h00000000, RESP_SLVERR, 32'h200,   3'd2, 32'hBEEFCD44, RESP_OKAY};
        vecs[5] = '{32'h20000, 3'd2,        4'hF, 32'h12345678, RESP_DECERR, 32'h20000, 3'd2, 32'h00000000, RESP_DECERR};
        vecs[6] = '{32'h204,   3'd2,        4'hF, 32'h55667788, RESP_OKAY,   32'h204,   3'd2, 32'h55667788, RESP_OKAY};
        vecs[7] = '{32'h204,   3'd2,        4'h0, 32'h00000000, RESP_OKAY,   32'h204,   3'd2, 32'h55667788, RESP_OKAY};
        vecs[8] = '{32'h204,   3'd0,        4'hF, 32'h99999999, RESP_OKAY,   32'h204,   3'd2, 32'h55667799, RESP_OKAY};
        vecs[9] = '{32'h208,   3'd2,        4'hF, 32'hCAFEF00D, RESP_OKAY,   32'h204,   3'd3, 32'h00000000, RESP_SLVERR};

        rst = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        repeat (3) @(negedge clk);
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_protocol_err", {63'd0, protocol_err}, 64'd0);
        chk("rst_console_valid", {63'd0, console_valid}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_awready", {63'd0, awready}, 64'd1);
        chk("idle_arready", {63'd0, arready}, 64'd1);

        // 4-beat INCR write then read back
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(8'h11 * (i + 1)); sbuf[i] = 4'hF; end
        axi_write(32'h100, 1'b1, 8'd3, 3'd2, BURST_INCR, -1, resp, bidv);
        chk("incr_bresp", 64'(resp), 64'(RESP_OKAY));
        chk("incr_bid", 64'(bidv), 64'd1);
        axi_read(32'h100, 1'b1, 8'd3, 3'd2, BURST_INCR, -1, 0);
        chk("incr_read_latency", 64'(rlat), 64'd2);
        for (int b = 0; b < 4; b++) begin
            chk("incr_rdata", 64'(rbuf_data[b]), 64'(8'h11 * (b + 1)));
            chk("incr_rlast", {63'd0, rbuf_last[b]}, {63'd0, b == 3});
            chk("incr_rid", 64'(rbuf_id[b]), 64'd1);
            chk("incr_rresp", 64'(rbuf_resp[b]), 64'(RESP_OKAY));
        end

        // WRAP read from 0x10C visits 0x10C, 0x100, 0x104, 0x108
        axi_read(32'h10C, 1'b0, 8'd3, 3'd2, BURST_WRAP, -1, 0);
        chk("wrap_b0", 64'(rbuf_data[0]), 64'h44);
        chk("wrap_b1", 64'(rbuf_data[1]), 64'h11);
        chk("wrap_b2", 64'(rbuf_data[2]), 64'h22);
        chk("wrap_b3", 64'(rbuf_data[3]), 64'h33);
        chk("wrap_rlast", {63'd0, rbuf_last[3]}, 64'd1);

        for (int v = 0; v < 10; v++) begin
            wbuf[0] = vecs[v].wdata;
            sbuf[0] = vecs[v].wstrb;
            axi_write(vecs[v].waddr, 1'b0, 8'd0, vecs[v].wsize, BURST_INCR, -1, resp, bidv);
            chk($sformatf("vec%0d_bresp", v), 64'(resp), 64'(vecs[v].exp_bresp));
            axi_read(vecs[v].raddr, 1'b0, 8'd0, vecs[v].rsize, BURST_INCR, -1, 0);
            chk($sformatf("vec%0d_rdata", v), 64'(rbuf_data[0]), 64'(vecs[v].exp_rdata));
            chk($sformatf("vec%0d_rresp", v), 64'(rbuf_resp[0]), 64'(vecs[v].exp_rresp));
            chk($sformatf("vec%0d_rlast", v), {63'd0, rbuf_last[0]}, 64'd1);
        end

        // FIXED burst keeps overwriting one word
        wbuf[0] = 32'h0000_0001; wbuf[1] = 32'h0000_0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write(32'h700, 1'b0, 8'd1, 3'd2, BURST_FIXED, -1, resp, bidv);
        axi_read(32'h700, 1'b0, 8'd0, 3'd2, BURST_INCR, -1, 0);
        chk("fixed_rdata", 64'(rbuf_data[0]), 64'h2);

        // Console sink
        wbuf[0] = 32'h0000_0041; sbuf[0] = 4'h1;
        axi_write(32'h1000_0000, 1'b1, 8'd0, 3'd2, BURST_INCR, -1, resp, bidv);
        @(negedge clk);
        chk("console_pulses", 64'(con_cnt), 64'd1);
        chk("console_data", 64'(con_data), 64'h41);
        chk("console_bresp", 64'(resp), 64'(RESP_OKAY));
        axi_read(32'h1000_0000, 1'b0, 8'd0, 3'd2, BURST_INCR, -1, 0);
        chk("console_rdata", 64'(rbuf_data[0]), 64'd0);
        chk("console_rresp", 64'(rbuf_resp[0]), 64'(RESP_OKAY));

        // Stalled 8-beat read alongside an independent 8-beat write
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
        axi_write(32'h400, 1'b0, 8'd7, 3'd2, BURST_INCR, -1, resp, bidv);
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hB0 + 32'(i);
        fork
            axi_write(32'h500, 1'b1, 8'd7, 3'd2, BURST_INCR, -1, resp, bidv);
            axi_read(32'h400, 1'b1, 8'd7, 3'd2, BURST_INCR, 3, 5);
        join
        for (int b = 0; b < 8; b++) begin
            chk("stall_rdata", 64'(rbuf_data[b]), 64'(32'hA0 + 32'(b)));
            chk("stall_rlast", {63'd0, rbuf_last[b]}, {63'd0, b == 7});
        end
        chk("conc_bresp", 64'(resp), 64'(RESP_OKAY));
        chk("conc_bid", 64'(bidv), 64'd1);
        axi_read(32'h500, 1'b0, 8'd7, 3'd2, BURST_INCR, -1, 0);
        for (int b = 0; b < 8; b++) chk("conc_wdata", 64'(rbuf_data[b]), 64'(32'hB0 + 32'(b)));

        // Early wlast on beat 2 of 4
        chk("perr_before", {63'd0, protocol_err}, 64'd0);
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h600 + 32'(i); sbuf[i] = 4'hF; end
        axi_write(32'h600, 1'b0, 8'd3, 3'd2, BURST_INCR, 1, resp, bidv);
        chk("perr_after", {63'd0, protocol_err}, 64'd1);
        chk("perr_bresp", 64'(resp), 64'(RESP_OKAY));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
